// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side instruction fields, global pipeline controls and the EX forwarding
// results exchanged between the core and the forwarding/hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  // id_valid qualifies every id_* field in the same cycle. There is no ready:
  // the controller answers with stall, and while stall=1 ID must hold its instruction.
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              ext_stall;
  logic              flush;
  logic [SEL_W-1:0]  ex_fwd_a;
  logic [SEL_W-1:0]  ex_fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_is_load, ext_stall, flush,
    input  ex_fwd_a, ex_fwd_b, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_is_load, ext_stall, flush,
    output ex_fwd_a, ex_fwd_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows destination tags of
// in-flight instructions and produces registered EX forward selects.
module fwd_hazard_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              is_load;
    logic [ADDR_W-1:0] rd;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  // pipe_q[k] is the instruction k stages past ID (1=EX, 2=MEM, ...).
  entry_t           pipe_q [1:NUM_STAGES];
  entry_t           id_entry;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             haz_a;
  logic             haz_b;
  logic             stall_w;
  logic             kill_id;
  logic [SEL_W-1:0] fwd_a_q;
  logic [SEL_W-1:0] fwd_b_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic produces(input entry_t e, input logic [ADDR_W-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

  assign id_entry = {bus.id_valid, bus.id_regwrite, bus.id_is_load, bus.id_rd};

  // Oldest-to-youngest scan so the youngest match overwrites; the last entry
  // has already written the regfile and is deliberately left out.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 1; s--) begin
      if (produces(pipe_q[s], bus.id_rs)) begin
        sel_a = SEL_W'(s + 1);
        haz_a = pipe_q[s].is_load && ((s + 1) < LOAD_READY);
      end
      if (produces(pipe_q[s], bus.id_rt)) begin
        sel_b = SEL_W'(s + 1);
        haz_b = pipe_q[s].is_load && ((s + 1) < LOAD_READY);
      end
    end
  end

  assign stall_w = bus.id_valid && !bus.flush && !bus.ext_stall && (haz_a || haz_b);
  assign kill_id = bus.flush || stall_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NUM_STAGES; k++) pipe_q[k] <= BUBBLE;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else if (!bus.ext_stall) begin
      pipe_q[1] <= kill_id ? BUBBLE : id_entry;
      for (int k = 2; k <= NUM_STAGES; k++) pipe_q[k] <= pipe_q[k-1];
      fwd_a_q <= kill_id ? '0 : sel_a;
      fwd_b_q <= kill_id ? '0 : sel_b;
      if (stall_w && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;
  assign bus.stall       = stall_w;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: default instance, a LOAD_READY=2
// instance and a CNT_W=2 instance, all fed the same ID stream.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.ADDR_W(5), .SEL_W(2), .CNT_W(16)) m_if ();
  fwd_hazard_ctrl_if #(.ADDR_W(5), .SEL_W(2), .CNT_W(16)) r_if ();
  fwd_hazard_ctrl_if #(.ADDR_W(5), .SEL_W(2), .CNT_W(2))  c_if ();

  fwd_hazard_ctrl #(.ADDR_W(5), .NUM_STAGES(3), .LOAD_READY(3), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(m_if));
  fwd_hazard_ctrl #(.ADDR_W(5), .NUM_STAGES(3), .LOAD_READY(2), .CNT_W(16)) u_lr2 (
    .clk(clk), .rst_n(rst_n), .bus(r_if));
  fwd_hazard_ctrl #(.ADDR_W(5), .NUM_STAGES(3), .LOAD_READY(3), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .bus(c_if));

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic ext, input logic fl);
    @(negedge clk);
    m_if.id_valid = v;  m_if.id_rs = rs;  m_if.id_rt = rt;  m_if.id_rd = rd;
    m_if.id_regwrite = rw;  m_if.id_is_load = ld;  m_if.ext_stall = ext;  m_if.flush = fl;
    r_if.id_valid = v;  r_if.id_rs = rs;  r_if.id_rt = rt;  r_if.id_rd = rd;
    r_if.id_regwrite = rw;  r_if.id_is_load = ld;  r_if.ext_stall = ext;  r_if.flush = fl;
    c_if.id_valid = v;  c_if.id_rs = rs;  c_if.id_rt = rt;  c_if.id_rd = rd;
    c_if.id_regwrite = rw;  c_if.id_is_load = ld;  c_if.ext_stall = ext;  c_if.flush = fl;
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    step(1'b1, rs, rt, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs);
    step(1'b1, rs, 5'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) nop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", m_if.stall); end
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    checks++; if (m_if.ex_fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b: got %0d want 0", m_if.ex_fwd_b); end
    checks++; if (m_if.stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", m_if.stall_count); end
    nop();
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_back_to_back();
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd3);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0b want 0", m_if.stall); end
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd2) begin errors++; $display("FAIL b2b_fwd_a: got %0d want 2", m_if.ex_fwd_a); end
    checks++; if (m_if.ex_fwd_b !== 2'd2) begin errors++; $display("FAIL b2b_fwd_b: got %0d want 2", m_if.ex_fwd_b); end
  endtask

  task automatic test_one_gap();
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    nop();
    alu(5'd5, 5'd3, 5'd1);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL gap_stall: got %0b want 0", m_if.stall); end
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd3) begin errors++; $display("FAIL gap_fwd_a: got %0d want 3", m_if.ex_fwd_a); end
    checks++; if (m_if.ex_fwd_b !== 2'd0) begin errors++; $display("FAIL gap_fwd_b: got %0d want 0", m_if.ex_fwd_b); end
  endtask

  task automatic test_youngest();
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd6, 5'd3, 5'd0);
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd2) begin errors++; $display("FAIL young_fwd_a: got %0d want 2", m_if.ex_fwd_a); end
    checks++; if (m_if.ex_fwd_b !== 2'd0) begin errors++; $display("FAIL young_fwd_b: got %0d want 0", m_if.ex_fwd_b); end
    idle(3);
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd6, 5'd0, 5'd0);
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL r0_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    // producer three slots back has retired: regfile already current
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    nop();
    nop();
    alu(5'd7, 5'd3, 5'd3);
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL retired_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    checks++; if (m_if.ex_fwd_b !== 2'd0) begin errors++; $display("FAIL retired_fwd_b: got %0d want 0", m_if.ex_fwd_b); end
  endtask

  task automatic test_load_use();
    idle(3);
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd0);
    checks++; if (m_if.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", m_if.stall); end
    checks++; if (r_if.stall !== 1'b0) begin errors++; $display("FAIL lu_lr2_stall: got %0b want 0", r_if.stall); end
    alu(5'd6, 5'd5, 5'd0);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_end: got %0b want 0", m_if.stall); end
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    checks++; if (r_if.ex_fwd_a !== 2'd2) begin errors++; $display("FAIL lu_lr2_fwd_a: got %0d want 2", r_if.ex_fwd_a); end
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd3) begin errors++; $display("FAIL lu_fwd_a: got %0d want 3", m_if.ex_fwd_a); end
    checks++; if (m_if.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", m_if.stall_count); end
    checks++; if (r_if.stall_count !== 16'd0) begin errors++; $display("FAIL lu_lr2_count: got %0d want 0", r_if.stall_count); end
  endtask

  task automatic test_flush();
    idle(3);
    load(5'd5, 5'd1);
    step(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", m_if.stall); end
    alu(5'd7, 5'd6, 5'd0);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL flush_next_stall: got %0b want 0", m_if.stall); end
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL flush_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    checks++; if (m_if.stall_count !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d want 1", m_if.stall_count); end
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL flush_killed_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
  endtask

  task automatic test_freeze();
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    load(5'd5, 5'd3);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL frz_stall[%0d]: got %0b want 0", i, m_if.stall); end
      checks++; if (m_if.ex_fwd_a !== 2'd2) begin errors++; $display("FAIL frz_fwd_a[%0d]: got %0d want 2", i, m_if.ex_fwd_a); end
    end
    alu(5'd6, 5'd5, 5'd0);
    checks++; if (m_if.ex_fwd_a !== 2'd2) begin errors++; $display("FAIL frz_rel_fwd_a: got %0d want 2", m_if.ex_fwd_a); end
    checks++; if (m_if.stall !== 1'b1) begin errors++; $display("FAIL frz_rel_stall: got %0b want 1", m_if.stall); end
    alu(5'd6, 5'd5, 5'd0);
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL frz_stall_end: got %0b want 0", m_if.stall); end
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL frz_bubble_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    nop();
    checks++; if (m_if.ex_fwd_a !== 2'd3) begin errors++; $display("FAIL frz_fwd_a: got %0d want 3", m_if.ex_fwd_a); end
    checks++; if (m_if.stall_count !== 16'd2) begin errors++; $display("FAIL frz_count: got %0d want 2", m_if.stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    alu(5'd3, 5'd1, 5'd2);
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd3);
    checks++; if (m_if.stall !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %0b want 1", m_if.stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0b want 0", m_if.stall); end
    checks++; if (m_if.ex_fwd_a !== 2'd0) begin errors++; $display("FAIL rms_fwd_a: got %0d want 0", m_if.ex_fwd_a); end
    checks++; if (m_if.stall_count !== 16'd0) begin errors++; $display("FAIL rms_count: got %0d want 0", m_if.stall_count); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (m_if.stall !== 1'b0) begin errors++; $display("FAIL rms_release_stall: got %0b want 0", m_if.stall); end
    nop();
    checks++; if (m_if.ex_fwd_b !== 2'd0) begin errors++; $display("FAIL rms_release_fwd_b: got %0d want 0", m_if.ex_fwd_b); end
    checks++; if (m_if.stall_count !== 16'd0) begin errors++; $display("FAIL rms_release_count: got %0d want 0", m_if.stall_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      idle(3);
      load(5'd5, 5'd1);
      alu(5'd6, 5'd5, 5'd0);
      checks++; if (c_if.stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: got %0b want 1", i, c_if.stall); end
      alu(5'd6, 5'd5, 5'd0);
    end
    nop();
    checks++; if (c_if.stall_count !== 2'd3) begin errors++; $display("FAIL sat_count2: got %0d want 3", c_if.stall_count); end
    checks++; if (m_if.stall_count !== 16'd4) begin errors++; $display("FAIL sat_count16: got %0d want 4", m_if.stall_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_one_gap();
    test_youngest();
    test_load_use();
    test_flush();
    test_freeze();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
